// File: rtl/i2c_read_reg_pkg.sv
// Shared definitions for the I2C register-read wrapper: FSM state encoding
// and the ADV7513 address constants used by the sequencer.
package i2c_read_reg_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_REG = 2'd1,
    RD_CMD   = 2'd2,
    RD_DATA  = 2'd3
  } state_t;

  localparam logic [6:0] ADV7513_CHIP_ADDR = 7'h39;
  localparam logic [7:0] ADV7513_REG_HPD   = 8'h42;
  localparam logic [7:0] ADV7513_REG_PLL   = 8'h9E;

endpackage

// File: rtl/i2c_read_reg.sv
// I2C register read wrapper: START, chip+W, reg, repeated START, chip+R,
// NUM_BYTES data bytes, STOP, driven through the shared i2c_master handshake.
// Optional build macro I2C_READ_TIMEOUT_EN adds an abort when the bus shows
// no busy edge for TIMEOUT_CYCLES clocks.
module i2c_read_reg
  import i2c_read_reg_pkg::*;
#(
  parameter int NUM_BYTES      = 1,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             chip_addr,
  input  logic [7:0]             reg_addr,
  input  logic                   enable,
  output logic                   done,
  output logic [8*NUM_BYTES-1:0] value,
  output logic                   ack_error,
  input  logic                   i2c_busy,
  input  logic [7:0]             i2c_data_rd,
  input  logic                   i2c_ack_error,
  output logic                   i2c_ena,
  output logic [6:0]             i2c_addr,
  output logic                   i2c_rw,
  output logic [7:0]             i2c_data_wr
);

  localparam int VW = 8 * NUM_BYTES;

  state_t     state;
  logic [1:0] byte_cnt;
  logic       busy_q;
  logic       rise;
  logic       fall;
  logic       last_byte;
  logic       timeout;

  // New byte enters at the LSB end; first received byte ends up in the MSBs.
  function automatic logic [VW-1:0] shift_byte(input logic [VW-1:0] cur,
                                               input logic [7:0]    b);
    logic [VW+7:0] wide;
    wide = {cur, b};
    return wide[VW-1:0];
  endfunction

  assign rise      = i2c_busy & ~busy_q;
  assign fall      = ~i2c_busy & busy_q;
  assign last_byte = (byte_cnt == 2'(NUM_BYTES - 1));
  assign done      = (state == IDLE) & ~i2c_busy;

`ifdef I2C_READ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_cnt;

  // Clocks since the last busy edge while a transaction is open.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE || rise || fall) tmo_cnt <= '0;
    else                                        tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout = (state != IDLE) && !rise && !fall &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Transaction FSM with registered i2c_master command outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      i2c_ena     <= 1'b0;
      i2c_rw      <= 1'b0;
      i2c_addr    <= '0;
      i2c_data_wr <= '0;
      value       <= '0;
      ack_error   <= 1'b0;
      byte_cnt    <= '0;
      busy_q      <= 1'b0;
    end else begin
      busy_q <= i2c_busy;
      case (state)
        IDLE: begin
          if (enable && done) begin
            i2c_addr    <= chip_addr;
            i2c_data_wr <= reg_addr;
            i2c_rw      <= 1'b0;
            i2c_ena     <= 1'b1;
            ack_error   <= 1'b0;
            byte_cnt    <= '0;
            state       <= SEND_REG;
          end
        end
        SEND_REG: begin
          // Master latched chip+W/reg; queue the repeated-start read.
          if (rise) begin
            i2c_rw <= 1'b1;
            state  <= RD_CMD;
          end
        end
        RD_CMD: begin
          // A read byte has started; drop ena on the last one so STOP follows.
          if (rise) begin
            if (last_byte) i2c_ena <= 1'b0;
            state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (fall) begin
            value <= shift_byte(value, i2c_data_rd);
            if (last_byte) begin
              state <= IDLE;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
              state    <= RD_CMD;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Any NACK seen at a byte boundary taints the whole transaction.
      if (fall && state != IDLE) ack_error <= ack_error | i2c_ack_error;

      if (timeout) begin
        i2c_ena   <= 1'b0;
        ack_error <= 1'b1;
        state     <= IDLE;
      end
    end
  end

endmodule
